// File: rtl/cnt_arb_seq_if.sv
// Handshake bundle between two sweep requesters, the sequencer and the shared counter.
// The master side is the requester/counter environment, the slave side is the sequencer.
interface cnt_arb_seq_if #(
  parameter int SIZECOUNT = 12
);
  logic                 req0;
  logic                 req1;
  logic [SIZECOUNT-1:0] start0;
  logic [SIZECOUNT-1:0] start1;
  logic [SIZECOUNT-1:0] end0;
  logic [SIZECOUNT-1:0] end1;
  logic                 step0;
  logic                 step1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 done0;
  logic                 done1;
  logic                 busy;
  logic                 cnt_clear;
  logic                 cnt_load;
  logic                 cnt_go;
  logic [SIZECOUNT-1:0] cnt_loadValue;
  logic [SIZECOUNT-1:0] cnt_maxValue;
  logic [SIZECOUNT-1:0] cnt_count;

  modport master (
    output req0, req1, start0, start1, end0, end1, step0, step1, cnt_count,
    input  gnt0, gnt1, done0, done1, busy,
    input  cnt_clear, cnt_load, cnt_go, cnt_loadValue, cnt_maxValue
  );

  modport slave (
    input  req0, req1, start0, start1, end0, end1, step0, step1, cnt_count,
    output gnt0, gnt1, done0, done1, busy,
    output cnt_clear, cnt_load, cnt_go, cnt_loadValue, cnt_maxValue
  );
endinterface

// File: rtl/cnt_arb_seq.sv
// Round-robin sequencer granting one of two requesters a sweep of the shared counter
// from its start value to its end value, then pulsing done and clearing the counter.
module cnt_arb_seq #(
  parameter int SIZECOUNT = 12
) (
  input logic          clk,
  input logic          reset,
  cnt_arb_seq_if.slave bus
);

  // state | meaning
  // IDLE  | no grant, waiting for a request
  // LOAD  | winner latched, counter loaded with its start value
  // RUN   | counter advances on the winner's step until it reaches end
  // DONE  | one-cycle done pulse and counter clear, then back to IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_idx;
  logic                 r_last;
  logic                 r_gnt0;
  logic                 r_gnt1;
  logic                 r_done0;
  logic                 r_done1;
  logic                 r_busy;
  logic                 r_clear;
  logic                 r_load;
  logic [SIZECOUNT-1:0] r_load_val;
  logic [SIZECOUNT-1:0] r_max_val;

  logic w_win;
  logic w_at_end;
  logic w_step;

  // On a tie the requester that was not served last wins; r_last resets to 1 so req0 wins first.
  assign w_win    = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
  assign w_at_end = (bus.cnt_count == r_max_val);
  assign w_step   = r_idx ? bus.step1 : bus.step0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 1'b0;
      r_last     <= 1'b1;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_busy     <= 1'b0;
      r_clear    <= 1'b0;
      r_load     <= 1'b0;
      r_load_val <= '0;
      r_max_val  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_state    <= S_LOAD;
            r_idx      <= w_win;
            r_load_val <= w_win ? bus.start1 : bus.start0;
            r_max_val  <= w_win ? bus.end1 : bus.end0;
            r_gnt0     <= ~w_win;
            r_gnt1     <= w_win;
            r_busy     <= 1'b1;
            r_load     <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= S_RUN;
          r_load  <= 1'b0;
        end
        S_RUN: begin
          if (w_at_end) begin
            r_state <= S_DONE;
            r_done0 <= ~r_idx;
            r_done1 <= r_idx;
            r_clear <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_last  <= r_idx;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_clear <= 1'b0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Advance must drop in the same cycle the counter reaches end, so it cannot be registered.
  assign bus.cnt_go        = (r_state == S_RUN) && w_step && !w_at_end;
  assign bus.gnt0          = r_gnt0;
  assign bus.gnt1          = r_gnt1;
  assign bus.done0         = r_done0;
  assign bus.done1         = r_done1;
  assign bus.busy          = r_busy;
  assign bus.cnt_clear     = r_clear;
  assign bus.cnt_load      = r_load;
  assign bus.cnt_loadValue = r_load_val;
  assign bus.cnt_maxValue  = r_max_val;

endmodule

// File: tb/tb_cnt_arb_seq.sv
// Directed bench for cnt_arb_seq with a behavioural model of the shared counter.
module tb_cnt_arb_seq;
  localparam int W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  cnt_arb_seq_if #(.SIZECOUNT(W)) bus ();

  cnt_arb_seq #(.SIZECOUNT(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter: clear > load > hold at max > increment on go, wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               bus.cnt_count <= '0;
    else if (bus.cnt_clear)                   bus.cnt_count <= '0;
    else if (bus.cnt_load)                    bus.cnt_count <= bus.cnt_loadValue;
    else if (bus.cnt_count == bus.cnt_maxValue) bus.cnt_count <= bus.cnt_count;
    else if (bus.cnt_go)                      bus.cnt_count <= bus.cnt_count + 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_gnt0"}, bus.gnt0, 0);
    chk({tag, "_gnt1"}, bus.gnt1, 0);
    chk({tag, "_done0"}, bus.done0, 0);
    chk({tag, "_done1"}, bus.done1, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_clear"}, bus.cnt_clear, 0);
    chk({tag, "_load"}, bus.cnt_load, 0);
    chk({tag, "_go"}, bus.cnt_go, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.step0 = 0; bus.step1 = 0;
    bus.start0 = '0; bus.start1 = '0; bus.end0 = '0; bus.end1 = '0;
    #12;
    idle_outputs("rst");
    chk("rst_ldval", bus.cnt_loadValue, 0);
    chk("rst_maxval", bus.cnt_maxValue, 0);
    #10 reset = 1'b1;
    tick();

    // Basic sweep 3..5 on requester 0
    bus.req0 = 1; bus.start0 = 3; bus.end0 = 5; bus.step0 = 1;
    tick();
    chk("t1_gnt0", bus.gnt0, 1);
    chk("t1_load", bus.cnt_load, 1);
    chk("t1_busy", bus.busy, 1);
    chk("t1_ldval", bus.cnt_loadValue, 3);
    chk("t1_maxval", bus.cnt_maxValue, 5);
    bus.req0 = 0;
    tick();
    chk("t2_cnt", bus.cnt_count, 3);
    chk("t2_go", bus.cnt_go, 1);
    chk("t2_load", bus.cnt_load, 0);
    tick();
    chk("t3_cnt", bus.cnt_count, 4);
    tick();
    chk("t4_cnt", bus.cnt_count, 5);
    chk("t4_go", bus.cnt_go, 0);
    tick();
    chk("t5_done0", bus.done0, 1);
    chk("t5_clear", bus.cnt_clear, 1);
    chk("t5_gnt0", bus.gnt0, 1);
    tick();
    idle_outputs("t6");
    chk("t6_cnt", bus.cnt_count, 0);
    chk("t6_ldval_hold", bus.cnt_loadValue, 3);
    chk("t6_maxval_hold", bus.cnt_maxValue, 5);

    // Fresh reset, then both requests held: grants alternate 0,1,0,1
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.req0 = 1; bus.req1 = 1; bus.step0 = 1; bus.step1 = 1;
    bus.start0 = 1; bus.end0 = 2; bus.start1 = 4; bus.end1 = 5;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt0", bus.gnt0, (k % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", bus.gnt1, (k % 2 == 1) ? 1 : 0);
      chk("rr_ldval", bus.cnt_loadValue, (k % 2 == 1) ? 4 : 1);
      tick();
      chk("rr_cnt_a", bus.cnt_count, (k % 2 == 1) ? 4 : 1);
      tick();
      chk("rr_cnt_b", bus.cnt_count, (k % 2 == 1) ? 5 : 2);
      tick();
      chk("rr_done", (k % 2 == 1) ? bus.done1 : bus.done0, 1);
      if (k == 3) begin
        bus.req0 = 0; bus.req1 = 0;
      end
      tick();
      chk("rr_idle_busy", bus.busy, 0);
      chk("rr_idle_gnt", {bus.gnt1, bus.gnt0}, 0);
    end
    tick();
    chk("rr_stays_idle", bus.busy, 0);

    // start == end: single RUN cycle with no advance
    bus.req1 = 1; bus.start1 = 7; bus.end1 = 7;
    tick();
    chk("eq_gnt1", bus.gnt1, 1);
    chk("eq_go_load", bus.cnt_go, 0);
    bus.req1 = 0;
    tick();
    chk("eq_cnt", bus.cnt_count, 7);
    chk("eq_go_run", bus.cnt_go, 0);
    chk("eq_done_early", bus.done1, 0);
    tick();
    chk("eq_done1", bus.done1, 1);
    chk("eq_go_done", bus.cnt_go, 0);
    tick();
    chk("eq_done_once", bus.done1, 0);
    chk("eq_idle", bus.busy, 0);

    // Wrap-around sweep 14 -> 1 at 4 bits
    bus.req0 = 1; bus.start0 = 14; bus.end0 = 1; bus.step0 = 1;
    tick();
    chk("wr_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    tick();
    chk("wr_cnt14", bus.cnt_count, 14);
    tick();
    chk("wr_cnt15", bus.cnt_count, 15);
    tick();
    chk("wr_cnt0", bus.cnt_count, 0);
    chk("wr_nodone", bus.done0, 0);
    tick();
    chk("wr_cnt1", bus.cnt_count, 1);
    chk("wr_go_end", bus.cnt_go, 0);
    tick();
    chk("wr_done0", bus.done0, 1);
    tick();
    chk("wr_idle", bus.busy, 0);

    // Step gating 1,0,0,1 with req0 dropped after grant
    bus.req0 = 1; bus.start0 = 2; bus.end0 = 4; bus.step0 = 1;
    tick();
    chk("st_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    tick();
    chk("st_cnt_a", bus.cnt_count, 2);
    chk("st_go_a", bus.cnt_go, 1);
    tick();
    chk("st_cnt_b", bus.cnt_count, 3);
    bus.step0 = 0;
    #1 chk("st_go_b", bus.cnt_go, 0);
    tick();
    chk("st_cnt_c", bus.cnt_count, 3);
    chk("st_go_c", bus.cnt_go, 0);
    chk("st_gnt_held", bus.gnt0, 1);
    tick();
    chk("st_cnt_d", bus.cnt_count, 3);
    bus.step0 = 1;
    #1 chk("st_go_d", bus.cnt_go, 1);
    tick();
    chk("st_cnt_e", bus.cnt_count, 4);
    chk("st_go_e", bus.cnt_go, 0);
    tick();
    chk("st_done0", bus.done0, 1);
    tick();
    chk("st_idle", bus.busy, 0);

    // Reset mid-RUN: immediate abort, no done, next tie goes to req0
    bus.req1 = 1; bus.start1 = 0; bus.end1 = 9; bus.step1 = 1;
    tick();
    chk("ar_gnt1", bus.gnt1, 1);
    bus.req1 = 0;
    tick();
    tick();
    chk("ar_running", bus.cnt_count, 1);
    #2 reset = 1'b0;
    #1;
    idle_outputs("ar");
    chk("ar_ldval", bus.cnt_loadValue, 0);
    chk("ar_maxval", bus.cnt_maxValue, 0);
    tick();
    idle_outputs("ar_hold");
    bus.req0 = 1; bus.req1 = 1;
    reset = 1'b1;
    tick();
    chk("ar_tie_gnt0", bus.gnt0, 1);
    chk("ar_tie_gnt1", bus.gnt1, 0);
    bus.req0 = 0; bus.req1 = 0;
    repeat (6) tick();
    chk("ar_final_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cnt_arb_seq.md
CNT_ARB_SEQ -- requirements
Module: cnt_arb_seq

Interface
REQ-001 Parameter SIZECOUNT, default 12, SHALL set the width of all count/value buses.
REQ-002 clk  input  1  SHALL be the system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low system reset (0 = reset asserted).
REQ-004 req0, req1  input  1 each  SHALL be the requester sweep requests, level-sensitive.
REQ-005 start0, start1  input  SIZECOUNT each  SHALL be the per-requester first count value, sampled at grant.
REQ-006 end0, end1  input  SIZECOUNT each  SHALL be the per-requester final count value, sampled at grant.
REQ-007 step0, step1  input  1 each  SHALL be the per-requester advance enables, honoured only while that requester holds the grant.
REQ-008 gnt0, gnt1  output  1 each  SHALL be the grant indicators, one-hot or zero.
REQ-009 done0, done1  output  1 each  SHALL be single-cycle sweep-complete pulses.
REQ-010 busy  output  1  SHALL be high in any state other than IDLE.
REQ-011 cnt_clear, cnt_load, cnt_go  output  1 each  SHALL be the shared counter's clear, load and enable controls.
REQ-012 cnt_loadValue, cnt_maxValue  output  SIZECOUNT each  SHALL be the shared counter's load and maximum values.
REQ-013 cnt_count  input  SIZECOUNT  SHALL be the shared counter's current value.

Function
REQ-014 The target counter SHALL be modelled as follows: registered; priority clear > load > hold at max > increment on go; wraps modulo 2^SIZECOUNT; one-cycle update latency.
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN and DONE; all outputs SHALL be decoded from the registered state and the latched grant/values.
REQ-016 In IDLE, if any req is high, the FSM SHALL go to LOAD at the next edge, latch the winner, its start into cnt_loadValue and its end into cnt_maxValue.
REQ-017 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; after reset, req0 wins the first tie.
REQ-018 The last-served pointer SHALL update on exit from DONE only.
REQ-019 In LOAD, cnt_load SHALL be 1; the next state SHALL unconditionally be RUN.
REQ-020 In RUN, cnt_go SHALL equal the granted requester's step while cnt_count != latched end, and SHALL be 0 when they are equal.
REQ-021 In RUN, cnt_count == latched end SHALL cause a transition to DONE at the next edge.
REQ-022 In DONE, done of the granted requester and cnt_clear SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-023 gntX SHALL be high from LOAD through DONE inclusive, and low in IDLE.
REQ-024 Deasserting req during LOAD/RUN SHALL have no effect; the sweep SHALL run to completion.
REQ-025 If start == end, RUN SHALL last exactly one cycle with cnt_go = 0.
REQ-026 If start > end, the sweep SHALL continue through wrap-around (2^SIZECOUNT-1 -> 0) until end is reached.
REQ-027 When step is low, RUN SHALL be held with cnt_go = 0 and no timeout.
REQ-028 A request pending at DONE SHALL be granted from the following IDLE cycle; there SHALL be a minimum of one IDLE cycle between sweeps.
REQ-029 cnt_loadValue and cnt_maxValue SHALL hold their last latched values while in IDLE.

Reset
REQ-030 While reset = 0, the module SHALL force: state IDLE; gnt, done, busy, cnt_clear, cnt_load and cnt_go all 0; cnt_loadValue and cnt_maxValue 0; pointer set so that req0 wins the next tie.
REQ-031 Reset assertion mid-sweep SHALL abort immediately with no done pulse; after release, a pending request SHALL be re-arbitrated from IDLE.

Verification
REQ-032 The bench SHALL cover: req0=1, start0=3, end0=5, step0=1 at T0 -> LOAD at T1; cnt_count 3/4/5 at T2/T3/T4; done0 at T5; IDLE at T6 with cnt_count = 0.
REQ-033 The bench SHALL cover: req0 and req1 both held high -> grants alternate 0,1,0,1 with one IDLE cycle between sweeps.
REQ-034 The bench SHALL cover: start1 = end1 = 7 -> RUN lasts 1 cycle, cnt_go never 1, done1 pulses once.
REQ-035 The bench SHALL cover: SIZECOUNT=4, start=14, end=1 -> count sequence 14,15,0,1, then done.
REQ-036 The bench SHALL cover: step0 toggled 1,0,0,1 during RUN -> count advances only on step cycles, and req0 dropping mid-RUN is ignored.
REQ-037 The bench SHALL cover: reset driven to 0 during RUN -> all outputs 0 asynchronously, no done pulse, and the next tie grants req0.
